// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Main control FSM for the multi-cycle MIPS datapath. Sequences
//             each instruction through fetch, decode, execute, memory and
//             write-back states and drives every datapath enable and mux
//             select. ALUOp feeds the ALU control decoder (00 add,
//             01 subtract, 10 decode by funct). The memory states stall on
//             mem_ready so variable-latency memory needs no datapath change.
//  Ports    : clk          rising-edge clock
//             rst_n        synchronous active-low reset
//             opcode[5:0]  instruction[31:26], stable from DECODE to FETCH
//             mem_ready    memory access completes this cycle
//             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//             MemtoReg, ALUSrcA, RegWrite, RegDst   datapath controls
//             PCSource[1:0] PC mux (00 ALU, 01 ALUOut, 10 jump target)
//             ALUSrcB[1:0]  ALU B mux (00 B, 01 4, 10 imm, 11 imm<<2)
//             ALUOp[1:0]    to the ALU control decoder
//             illegal_op    one-cycle flag in DECODE for unsupported opcode
//             state[3:0]    current state, for debug
//  Config   : MULTICYCLE_CONTROL_ADDI_EN - when defined, opcode 001000 (addi)
//             executes through ADDIEX/ADDIWB; otherwise it is illegal and the
//             ADDIEX/ADDIWB encodings are unused.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    // State encoding
    localparam logic [3:0] c_st_rst    = 4'hF;
    localparam logic [3:0] c_st_fetch  = 4'h0;
    localparam logic [3:0] c_st_decode = 4'h1;
    localparam logic [3:0] c_st_memadr = 4'h2;
    localparam logic [3:0] c_st_memrd  = 4'h3;
    localparam logic [3:0] c_st_memwb  = 4'h4;
    localparam logic [3:0] c_st_memwr  = 4'h5;
    localparam logic [3:0] c_st_exec   = 4'h6;
    localparam logic [3:0] c_st_aluwb  = 4'h7;
    localparam logic [3:0] c_st_branch = 4'h8;
    localparam logic [3:0] c_st_jump   = 4'h9;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    localparam logic [3:0] c_st_addiex = 4'hA;
    localparam logic [3:0] c_st_addiwb = 4'hB;
`endif

    // Opcodes
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    localparam logic [5:0] c_op_addi  = 6'b001000;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_rst;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next_state = c_st_rst;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        PCSource     = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        illegal_op   = 1'b0;

        case (r_state)
            c_st_rst: begin
                w_next_state = c_st_fetch;
            end
            c_st_fetch: begin
                // A stalled fetch must commit neither the IR nor PC+4.
                MemRead      = 1'b1;
                ALUSrcB      = 2'b01;
                IRWrite      = mem_ready;
                PCWrite      = mem_ready;
                w_next_state = mem_ready ? c_st_decode : c_st_fetch;
            end
            c_st_decode: begin
                // Branch target is computed speculatively here with ALUOp=00.
                ALUSrcB = 2'b11;
                case (opcode)
                    c_op_lw, c_op_sw: w_next_state = c_st_memadr;
                    c_op_rtype:       w_next_state = c_st_exec;
                    c_op_beq:         w_next_state = c_st_branch;
                    c_op_j:           w_next_state = c_st_jump;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
                    c_op_addi:        w_next_state = c_st_addiex;
`endif
                    default: begin
                        w_next_state = c_st_fetch;
                        illegal_op   = 1'b1;
                    end
                endcase
            end
            c_st_memadr: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                // Only lw and sw reach this state; opcode is held stable.
                w_next_state = (opcode == c_op_sw) ? c_st_memwr : c_st_memrd;
            end
            c_st_memrd: begin
                MemRead      = 1'b1;
                IorD         = 1'b1;
                w_next_state = mem_ready ? c_st_memwb : c_st_memrd;
            end
            c_st_memwb: begin
                MemtoReg     = 1'b1;
                RegWrite     = 1'b1;
                w_next_state = c_st_fetch;
            end
            c_st_memwr: begin
                MemWrite     = 1'b1;
                IorD         = 1'b1;
                w_next_state = mem_ready ? c_st_fetch : c_st_memwr;
            end
            c_st_exec: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_next_state = c_st_aluwb;
            end
            c_st_aluwb: begin
                RegDst       = 1'b1;
                RegWrite     = 1'b1;
                w_next_state = c_st_fetch;
            end
            c_st_branch: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                w_next_state = c_st_fetch;
            end
            c_st_jump: begin
                PCWrite      = 1'b1;
                PCSource     = 2'b10;
                w_next_state = c_st_fetch;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            c_st_addiex: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = c_st_addiwb;
            end
            c_st_addiwb: begin
                RegWrite     = 1'b1;
                w_next_state = c_st_fetch;
            end
`endif
            default: begin
                // Unused encodings recover through RST with all outputs low.
                w_next_state = c_st_rst;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath, directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. Its 2-bit `ALUOp` output feeds the ALU control decoder: 00 means add, 01 means subtract, 10 means decode by funct. Memory states stall on a ready handshake, so variable-latency memory works without changes to the datapath.

## Interface
- No parameters. State encoding is fixed 4-bit, see Operation.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `opcode`  in  6  instruction[31:26] from the instruction register; stable from DECODE until the next FETCH.
- `mem_ready`  in  1  memory access completes this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls.
- `PCSource`  out  2  PC mux: 00 ALU, 01 ALUOut, 10 jump target.
- `ALUSrcB`  out  2  ALU B mux: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALUOp`  out  2  to the ALU control decoder.
- `illegal_op`  out  1  one-cycle flag for an unsupported opcode.
- `state`  out  4  current state, for debug.

## Operation
- State encoding: RST=F, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=A, ADDIWB=B.
- Outputs are a decode of `state`. Any output not listed for a state is 0.
  - RST: all outputs 0.
  - FETCH: MemRead=1, ALUSrcB=01. `IRWrite` and `PCWrite` equal `mem_ready`, so a stalled fetch writes neither IR nor PC.
  - DECODE: ALUSrcB=11. ALUOp=00 computes the branch target.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
- Transitions:
  - RST→FETCH unconditionally.
  - FETCH→DECODE when `mem_ready`=1, otherwise hold.
  - DECODE branches on `opcode`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXEC.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - 001000 (addi) → ADDIEX, only when the macro is defined.
    - Anything else → FETCH with `illegal_op`=1 for that DECODE cycle.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB on `mem_ready`, otherwise hold.
  - MEMWR→FETCH on `mem_ready`, otherwise hold.
  - MEMWB, ALUWB, BRANCH, JUMP and ADDIWB → FETCH.
  - EXEC→ALUWB.
  - ADDIEX→ADDIWB.
  - Unused encodings → RST.
- `illegal_op` is the only output that depends on `opcode`. It is 0 in every state other than DECODE.

## Timing
- When `rst_n`=0 at a rising edge, `state` becomes RST and all outputs read 0 for that cycle. Reset wins over any other transition, including mid-instruction and mid-stall.
- The first FETCH occurs in the cycle after reset is released.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4.
- Each wait cycle adds one cycle in FETCH, MEMRD or MEMWR. Outputs remain asserted while stalled.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- Outputs settle combinationally after the clock edge. The datapath samples them on the next edge.

## Configuration
- `MULTICYCLE_CONTROL_ADDI_EN`:
  - Defined: opcode 001000 executes through ADDIEX and ADDIWB.
  - Undefined: ADDIEX and ADDIWB encodings are unused and map to RST. Opcode 001000 is treated as illegal and raises `illegal_op`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release with `mem_ready`=1 → state F with all outputs 0, then state 0 with MemRead=1, PCWrite=1, IRWrite=1, ALUSrcB=01.
- lw, zero wait: `opcode`=100011, `mem_ready`=1 → state sequence 0,1,2,3,4,0. State 4 shows RegWrite=1 and MemtoReg=1. ALUOp=00 throughout.
- Stalled sw: `opcode`=101011, `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMWR → states 0×4, 1, 2, 5×3, 0. PCWrite is 1 only in the last FETCH cycle. MemWrite=1 for all 3 MEMWR cycles.
- R-type and beq: `opcode`=000000 → states 0,1,6,7 with ALUOp=10 in state 6 and RegDst=1 in state 7. `opcode`=000100 → states 0,1,8 with ALUOp=01, PCWriteCond=1, PCSource=01.
- Illegal and addi: `opcode`=111111 → `illegal_op`=1 in state 1, next state 0. `opcode`=001000 → states 0,1,A,B with macro defined; `illegal_op`=1 with it undefined.
- Reset mid-stall: assert `rst_n`=0 during MEMRD with `mem_ready`=0 → next state F, MemRead=0 and IorD=0.
